read_check_ecc: RTL and testbench

// Read-path ECC checker, downstream of the page-write datapath: consumes the 128-byte chunks and 3-byte ECC codes that the write path stored in NAND.
// - Recomputes each chunk's Hamming code and compares it with the stored code.
// - Classifies each chunk as clean, correctable, ECC-field error or uncorrectable, and reports the error location for correction.
// - Feeds the read buffer fix-up logic and the page status register.

---
 rtl/read_check_ecc_if.sv | 31 +++
 rtl/read_check_ecc.sv | 212 +++++++++++++++++++++
 tb/tb_read_check_ecc.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/read_check_ecc_if.sv
// Read-path ECC checker bus: page data and stored-ECC inputs, per-chunk result outputs.
interface read_check_ecc_if;
   logic       start;
   logic [7:0] din;
   logic       din_valid;
   logic [7:0] ecc_in;
   logic       ecc_valid;
   logic       busy;
   logic       result_valid;
   logic [1:0] status;
   logic [6:0] err_byte;
   logic [2:0] err_bit;
   logic [5:0] chunk_idx;
   logic [6:0] corr_cnt;
   logic       uncorr;
   logic       page_done;

   // Driver side: flash IO / sequencer.
   modport master (
      output start, din, din_valid, ecc_in, ecc_valid,
      input  busy, result_valid, status, err_byte, err_bit, chunk_idx, corr_cnt, uncorr,
             page_done
   );

   // Checker side.
   modport slave (
      input  start, din, din_valid, ecc_in, ecc_valid,
      output busy, result_valid, status, err_byte, err_bit, chunk_idx, corr_cnt, uncorr,
             page_done
   );
endinterface

// File: rtl/read_check_ecc.sv
// Read-path ECC checker: recomputes the Hamming code of each 128-byte chunk, compares it
// with the 3 stored ECC bytes and classifies the chunk (clean / corrected / code error /
// uncorrectable), reporting the bad bit location for the read-buffer fix-up logic.
module read_check_ecc #(
   parameter int unsigned CHUNKS = 64
) (
   input logic            clk,
   input logic            rst,
   read_check_ecc_if.slave bus
);

   localparam logic [5:0] LastChunk = 6'(CHUNKS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StData,
      StEcc0,
      StEcc1,
      StEcc2,
      StEval
   } state_e;

   state_e      state_q;
   logic [6:0]  byte_cnt_q;
   logic [5:0]  chunk_q;
   logic [13:0] rp_acc_q;
   logic [5:0]  cp_acc_q;
   logic [7:0]  rp_lo_q;
   logic [5:0]  rp_hi_q;

   logic        busy_q;
   logic        result_valid_q;
   logic [1:0]  status_q;
   logic [6:0]  err_byte_q;
   logic [2:0]  err_bit_q;
   logic [5:0]  chunk_idx_q;
   logic [6:0]  corr_cnt_q;
   logic        uncorr_q;
   logic        page_done_q;

   logic        parity;
   logic [13:0] rp_byte;
   logic [5:0]  cp_byte;

   logic [13:0] syn_rp;
   logic [5:0]  syn_cp;
   logic        pairs_ok;
   logic [1:0]  status_c;
   logic [6:0]  err_byte_c;
   logic [2:0]  err_bit_c;

   // The top two bits of the stored rp-high and cp bytes are constant padding.
   logic        unused_ecc_pad;
   assign unused_ecc_pad = ^bus.ecc_in[7:6];

   assign bus.busy         = busy_q;
   assign bus.result_valid = result_valid_q;
   assign bus.status       = status_q;
   assign bus.err_byte     = err_byte_q;
   assign bus.err_bit      = err_bit_q;
   assign bus.chunk_idx    = chunk_idx_q;
   assign bus.corr_cnt     = corr_cnt_q;
   assign bus.uncorr       = uncorr_q;
   assign bus.page_done    = page_done_q;

   // Per-byte code contribution: row parity steered by byte offset, column bits by bit index.
   always_comb begin
      parity  = ^bus.din;
      rp_byte = '0;
      cp_byte = '0;
      for (int k = 0; k < 7; k++) begin
         if (byte_cnt_q[k]) begin
            rp_byte[2*k+1] = parity;
         end else begin
            rp_byte[2*k] = parity;
         end
      end
      for (int b = 0; b < 8; b++) begin
         for (int k = 0; k < 3; k++) begin
            if (((b >> k) & 1) == 1) begin
               cp_byte[2*k+1] = cp_byte[2*k+1] ^ bus.din[b];
            end else begin
               cp_byte[2*k] = cp_byte[2*k] ^ bus.din[b];
            end
         end
      end
   end

   // Syndrome and classification; the cp byte is taken straight off the bus in ECC2.
   always_comb begin
      syn_rp     = rp_acc_q ^ {rp_hi_q, rp_lo_q};
      syn_cp     = cp_acc_q ^ bus.ecc_in[5:0];
      pairs_ok   = 1'b1;
      err_byte_c = '0;
      err_bit_c  = '0;
      for (int k = 0; k < 7; k++) begin
         if (syn_rp[2*k] == syn_rp[2*k+1]) pairs_ok = 1'b0;
         err_byte_c[k] = syn_rp[2*k+1];
      end
      for (int k = 0; k < 3; k++) begin
         if (syn_cp[2*k] == syn_cp[2*k+1]) pairs_ok = 1'b0;
         err_bit_c[k] = syn_cp[2*k+1];
      end
      if ((syn_rp == '0) && (syn_cp == '0)) begin
         status_c = 2'd0;
      end else if (pairs_ok) begin
         status_c = 2'd1;
      end else if ($countones({syn_rp, syn_cp}) == 1) begin
         status_c = 2'd2;
      end else begin
         status_c = 2'd3;
      end
      // Location is only meaningful for a correctable data bit.
      if (status_c != 2'd1) begin
         err_byte_c = '0;
         err_bit_c  = '0;
      end
   end

   // Chunk sequencing, code accumulation and registered result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= StIdle;
         byte_cnt_q     <= '0;
         chunk_q        <= '0;
         rp_acc_q       <= '0;
         cp_acc_q       <= '0;
         rp_lo_q        <= '0;
         rp_hi_q        <= '0;
         busy_q         <= 1'b0;
         result_valid_q <= 1'b0;
         status_q       <= '0;
         err_byte_q     <= '0;
         err_bit_q      <= '0;
         chunk_idx_q    <= '0;
         corr_cnt_q     <= '0;
         uncorr_q       <= 1'b0;
         page_done_q    <= 1'b0;
      end else begin
         result_valid_q <= 1'b0;
         page_done_q    <= 1'b0;
         if (bus.start) begin
            // Start (also mid-page) drops any partial chunk without a result.
            state_q     <= StData;
            byte_cnt_q  <= '0;
            chunk_q     <= '0;
            rp_acc_q    <= '0;
            cp_acc_q    <= '0;
            busy_q      <= 1'b1;
            chunk_idx_q <= '0;
            corr_cnt_q  <= '0;
            uncorr_q    <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: ;
               StData: begin
                  if (bus.din_valid) begin
                     rp_acc_q   <= rp_acc_q ^ rp_byte;
                     cp_acc_q   <= cp_acc_q ^ cp_byte;
                     byte_cnt_q <= byte_cnt_q + 7'd1;
                     if (byte_cnt_q == 7'd127) state_q <= StEcc0;
                  end
               end
               StEcc0: begin
                  if (bus.ecc_valid) begin
                     rp_lo_q <= bus.ecc_in;
                     state_q <= StEcc1;
                  end
               end
               StEcc1: begin
                  if (bus.ecc_valid) begin
                     rp_hi_q <= bus.ecc_in[5:0];
                     state_q <= StEcc2;
                  end
               end
               StEcc2: begin
                  if (bus.ecc_valid) begin
                     result_valid_q <= 1'b1;
                     status_q       <= status_c;
                     err_byte_q     <= err_byte_c;
                     err_bit_q      <= err_bit_c;
                     chunk_idx_q    <= chunk_q;
                     if (((status_c == 2'd1) || (status_c == 2'd2)) && (corr_cnt_q != 7'd127)) begin
                        corr_cnt_q <= corr_cnt_q + 7'd1;
                     end
                     if (status_c == 2'd3) uncorr_q <= 1'b1;
                     if (chunk_q == LastChunk) begin
                        page_done_q <= 1'b1;
                        busy_q      <= 1'b0;
                     end
                     state_q <= StEval;
                  end
               end
               StEval: begin
                  rp_acc_q   <= '0;
                  cp_acc_q   <= '0;
                  byte_cnt_q <= '0;
                  if (chunk_q == LastChunk) begin
                     chunk_q <= '0;
                     state_q <= StIdle;
                  end else begin
                     chunk_q <= chunk_q + 6'd1;
                     state_q <= StData;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_read_check_ecc.sv
// Bench for read_check_ecc: directed chunks from the spec plus randomized pages, with a
// scoreboard fed by a behavioural code/classification model.
module tb_read_check_ecc;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   read_check_ecc_if bus ();

   read_check_ecc #(.CHUNKS(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef logic [7:0] chunk_t [128];
   typedef struct {
      logic [1:0] status;
      logic [6:0] eb;
      logic [2:0] ebit;
      logic [5:0] idx;
      logic [6:0] corr;
      logic       uncorr;
      logic       done;
      logic       busy;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   m_chunk  = 0;
   int   m_corr   = 0;
   bit   m_uncorr = 1'b0;
   bit   gaps     = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Code as defined: 3 bytes rp[7:0], rp[15:8], cp[7:0].
   function automatic logic [23:0] ecc_of(input chunk_t d);
      logic [15:0] rp;
      logic [7:0]  cp;
      logic        p;
      rp = 16'hC000;
      cp = 8'hC0;
      for (int a = 0; a < 128; a++) begin
         p = ^d[a];
         for (int k = 0; k < 7; k++) rp[2*k + ((a >> k) & 1)] ^= p;
         for (int b = 0; b < 8; b++) begin
            if (d[a][b]) begin
               for (int k = 0; k < 3; k++) cp[2*k + ((b >> k) & 1)] ^= 1'b1;
            end
         end
      end
      return {rp[7:0], rp[15:8], cp};
   endfunction

   // Status 1 means the syndrome is exactly that of one flipped data bit: guess the bit
   // from the syndrome and confirm by encoding a chunk holding only that bit.
   function automatic void expect_result(input logic [23:0] calc, input logic [23:0] stored);
      logic [19:0] s;
      logic [23:0] fs;
      chunk_t      one;
      exp_t        e;
      int          a;
      int          b;
      s = {calc[13:8], calc[23:16], calc[5:0]} ^ {stored[13:8], stored[23:16], stored[5:0]};
      e.eb   = '0;
      e.ebit = '0;
      if (s == '0) begin
         e.status = 2'd0;
      end else if ($countones(s) == 1) begin
         e.status = 2'd2;
      end else begin
         a = 0;
         b = 0;
         for (int k = 0; k < 7; k++) if (s[6 + 2*k + 1]) a += (1 << k);
         for (int k = 0; k < 3; k++) if (s[2*k + 1]) b += (1 << k);
         foreach (one[i]) one[i] = 8'h00;
         one[a][b] = 1'b1;
         fs = ecc_of(one);
         if ({fs[13:8], fs[23:16], fs[5:0]} == s) begin
            e.status = 2'd1;
            e.eb     = 7'(a);
            e.ebit   = 3'(b);
         end else begin
            e.status = 2'd3;
         end
      end
      if ((e.status == 2'd1 || e.status == 2'd2) && m_corr < 127) m_corr++;
      if (e.status == 2'd3) m_uncorr = 1'b1;
      e.idx    = 6'(m_chunk);
      e.corr   = 7'(m_corr);
      e.uncorr = m_uncorr;
      e.done   = (m_chunk == 63);
      e.busy   = (m_chunk != 63);
      m_chunk++;
      sb.push_back(e);
   endfunction

   // Monitor: pop and compare whenever a result appears.
   always @(negedge clk) begin
      if (!rst && bus.result_valid) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got result_valid=1, expected 0 at %0t", $time);
         end else begin
            mon_e = sb.pop_front();
            check("status", 32'(bus.status), 32'(mon_e.status));
            check("err_byte", 32'(bus.err_byte), 32'(mon_e.eb));
            check("err_bit", 32'(bus.err_bit), 32'(mon_e.ebit));
            check("chunk_idx", 32'(bus.chunk_idx), 32'(mon_e.idx));
            check("corr_cnt", 32'(bus.corr_cnt), 32'(mon_e.corr));
            check("uncorr", 32'(bus.uncorr), 32'(mon_e.uncorr));
            check("page_done", 32'(bus.page_done), 32'(mon_e.done));
            check("busy", 32'(bus.busy), 32'(mon_e.busy));
         end
      end
      if (!rst && bus.page_done && !bus.result_valid) begin
         n_checks++;
         n_fail++;
         $display("FAIL page_done_alone: got page_done=1 result_valid=0, expected both at %0t",
                  $time);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] v);
      while (gaps && $urandom_range(0, 3) == 0) begin
         bus.din       = 8'($urandom);
         bus.din_valid = 1'b0;
         bus.ecc_in    = 8'($urandom);
         bus.ecc_valid = 1'($urandom_range(0, 1));
         cyc();
      end
      bus.din       = v;
      bus.din_valid = 1'b1;
      bus.ecc_in    = 8'($urandom);
      bus.ecc_valid = 1'($urandom_range(0, 1));
      cyc();
      bus.din_valid = 1'b0;
      bus.ecc_valid = 1'b0;
   endtask

   task automatic send_ecc(input logic [7:0] v);
      while (gaps && $urandom_range(0, 3) == 0) begin
         bus.ecc_in    = 8'($urandom);
         bus.ecc_valid = 1'b0;
         bus.din       = 8'($urandom);
         bus.din_valid = 1'($urandom_range(0, 1));
         cyc();
      end
      bus.ecc_in    = v;
      bus.ecc_valid = 1'b1;
      bus.din       = 8'($urandom);
      bus.din_valid = 1'($urandom_range(0, 1));
      cyc();
      bus.din_valid = 1'b0;
      bus.ecc_valid = 1'b0;
   endtask

   task automatic send_chunk(input chunk_t d, input logic [23:0] code);
      for (int i = 0; i < 128; i++) send_byte(d[i]);
      send_ecc(code[23:16]);
      send_ecc(code[15:8]);
      expect_result(ecc_of(d), code);
      send_ecc(code[7:0]);
      @(negedge clk);
      check("latency", 32'(bus.result_valid), 32'd1);
      cyc();
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      m_chunk   = 0;
      m_corr    = 0;
      m_uncorr  = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_result_valid"}, 32'(bus.result_valid), 32'd0);
      check({tag, "_status"}, 32'(bus.status), 32'd0);
      check({tag, "_err_byte"}, 32'(bus.err_byte), 32'd0);
      check({tag, "_err_bit"}, 32'(bus.err_bit), 32'd0);
      check({tag, "_chunk_idx"}, 32'(bus.chunk_idx), 32'd0);
      check({tag, "_corr_cnt"}, 32'(bus.corr_cnt), 32'd0);
      check({tag, "_uncorr"}, 32'(bus.uncorr), 32'd0);
      check({tag, "_page_done"}, 32'(bus.page_done), 32'd0);
   endtask

   function automatic void rand_chunk(output chunk_t d);
      foreach (d[i]) d[i] = 8'($urandom);
   endfunction

   function automatic void flip(inout chunk_t d, input int pos);
      d[pos / 8][pos % 8] = ~d[pos / 8][pos % 8];
   endfunction

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      chunk_t      ff;
      chunk_t      d;
      logic [23:0] code;
      int          p1;
      int          mode;

      bus.start     = 1'b0;
      bus.din       = '0;
      bus.din_valid = 1'b0;
      bus.ecc_in    = '0;
      bus.ecc_valid = 1'b0;
      rst           = 1'b1;
      foreach (ff[i]) ff[i] = 8'hFF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      cyc();

      // Directed chunks of page 1.
      pulse_start();
      @(negedge clk);
      check("start_busy", 32'(bus.busy), 32'd1);
      send_chunk(ff, 24'h00C0C0);
      check("clean_status", 32'(bus.status), 32'd0);
      check("clean_err_byte", 32'(bus.err_byte), 32'd0);
      d = ff;
      d[5] = 8'hF7;
      send_chunk(d, 24'h00C0C0);
      check("single_status", 32'(bus.status), 32'd1);
      check("single_err_byte", 32'(bus.err_byte), 32'd5);
      check("single_err_bit", 32'(bus.err_bit), 32'd3);
      check("single_corr_cnt", 32'(bus.corr_cnt), 32'd1);
      send_chunk(ff, 24'h01C0C0);
      check("code_status", 32'(bus.status), 32'd2);
      check("code_corr_cnt", 32'(bus.corr_cnt), 32'd2);
      check("code_uncorr", 32'(bus.uncorr), 32'd0);
      d[9] = 8'hFE;
      send_chunk(d, 24'h00C0C0);
      check("double_status", 32'(bus.status), 32'd3);
      check("double_uncorr", 32'(bus.uncorr), 32'd1);
      send_chunk(ff, 24'h00C0C0);
      check("sticky_status", 32'(bus.status), 32'd0);
      check("sticky_uncorr", 32'(bus.uncorr), 32'd1);

      // Random chunks with random faults fill out page 1.
      gaps = 1'b1;
      for (int c = 5; c < 64; c++) begin
         rand_chunk(d);
         code = ecc_of(d);
         mode = $urandom_range(0, 4);
         p1   = $urandom_range(0, 1023);
         if (mode == 1) flip(d, p1);
         if (mode == 2) begin
            flip(d, p1);
            flip(d, (p1 + 1 + $urandom_range(0, 1022)) % 1024);
         end
         if (mode == 3) code = code ^ (24'd1 << $urandom_range(0, 23));
         if (mode == 4) code = 24'($urandom);
         send_chunk(d, code);
      end
      check("page1_busy_low", 32'(bus.busy), 32'd0);

      // Page 2: 64 clean random chunks with gaps.
      pulse_start();
      for (int c = 0; c < 64; c++) begin
         rand_chunk(d);
         send_chunk(d, ecc_of(d));
      end
      check("page2_busy_low", 32'(bus.busy), 32'd0);
      check("page2_corr_cnt", 32'(bus.corr_cnt), 32'd0);
      check("page2_uncorr", 32'(bus.uncorr), 32'd0);
      check("page2_last_idx", 32'(bus.chunk_idx), 32'd63);

      // Abort mid-chunk with start, then reset mid-ECC1.
      pulse_start();
      rand_chunk(d);
      code = ecc_of(d);
      flip(d, $urandom_range(0, 1023));
      send_chunk(d, code);
      rand_chunk(d);
      code = ecc_of(d);
      flip(d, 17);
      flip(d, 600);
      send_chunk(d, code);
      rand_chunk(d);
      for (int i = 0; i < 40; i++) send_byte(d[i]);
      pulse_start();
      @(negedge clk);
      check("abort_busy", 32'(bus.busy), 32'd1);
      check("abort_corr_cnt", 32'(bus.corr_cnt), 32'd0);
      check("abort_uncorr", 32'(bus.uncorr), 32'd0);
      check("abort_chunk_idx", 32'(bus.chunk_idx), 32'd0);
      rand_chunk(d);
      send_chunk(d, ecc_of(d));
      rand_chunk(d);
      code = ecc_of(d);
      for (int i = 0; i < 128; i++) send_byte(d[i]);
      send_ecc(code[23:16]);
      bus.ecc_valid = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all_zero("rst");
      rst = 1'b0;
      cyc();

      // Data while idle is ignored; a fresh page starts at chunk 0.
      for (int i = 0; i < 4; i++) send_byte(8'($urandom));
      @(negedge clk);
      check("idle_busy", 32'(bus.busy), 32'd0);
      pulse_start();
      rand_chunk(d);
      send_chunk(d, ecc_of(d));

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
